// File: rtl/lbp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lbp_pkg
//  Description : Shared constants for the LBP gray-image datapath: image
//                geometry, gray port widths and the read-arbiter state
//                encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package lbp_pkg;

    localparam int ADDR_W = 14;   // 128x128 gray image
    localparam int DATA_W = 8;    // gray pixel width
    localparam int IMG_W  = 128;  // image width in pixels

    // Read-arbiter state encoding
    localparam logic ARB_WAIT_RDY = 1'b0;
    localparam logic ARB_RUN      = 1'b1;

endpackage : lbp_pkg
`default_nettype wire

// File: rtl/gray_rd_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin priority picker. Returns the first
//                asserted request at or after i_ptr, wrapping modulo NREQ.
//  Ports       : i_req  - request vector
//                i_ptr  - index holding top priority
//                o_gnt  - one-hot grant (zero when no request)
//                o_idx  - index of the granted request (0 when none)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx
);

    logic w_found;

    // Scan NREQ positions starting at the pointer; the first hit wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && i_req[(int'(i_ptr) + k) % NREQ]) begin
                w_found                             = 1'b1;
                o_gnt[(int'(i_ptr) + k) % NREQ]     = 1'b1;
                o_idx                               = IDX_W'((int'(i_ptr) + k) % NREQ);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/gray_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : gray_rd_arb
//  Description : Round-robin arbiter sharing the single gray-image read port
//                among NREQ requesters, with optional burst locking and a
//                stall while the memory is not ready.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                gray_ready        - memory ready (no reads issued while low)
//                gray_data         - memory data for the presented address
//                gray_addr/gray_req- registered read address / strobe
//                req_i/lock_i      - per-requester request / burst lock
//                addr_i            - packed per-requester addresses
//                gnt_o             - combinational one-hot grant
//                rvalid_o          - registered one-hot read-data valid
//                rdata_o           - pass-through of gray_data
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_rd_arb #(
    parameter int NREQ      = 2,
    parameter int ADDR_W    = lbp_pkg::ADDR_W,
    parameter int DATA_W    = lbp_pkg::DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     gray_ready,
    input  logic [DATA_W-1:0]        gray_data,
    output logic [ADDR_W-1:0]        gray_addr,
    output logic                     gray_req,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ-1:0]          lock_i,
    input  logic [NREQ*ADDR_W-1:0]   addr_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [NREQ-1:0]          rvalid_o,
    output logic [DATA_W-1:0]        rdata_o
);

    import lbp_pkg::*;

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BC_W  = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0]  c_max_burst = BC_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(NREQ - 1);

    logic              r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_last;
    logic [BC_W-1:0]   r_burst;
    logic [ADDR_W-1:0] r_addr;
    logic              r_req;
    logic [NREQ-1:0]   r_rvalid;

    logic [NREQ-1:0]   w_rr_gnt;
    logic [IDX_W-1:0]  w_rr_idx;
    logic              w_keep;
    logic              w_grant;
    logic [IDX_W-1:0]  w_win;
    logic              w_state_nxt;
    logic [IDX_W-1:0]  w_ptr_nxt;
    logic [IDX_W-1:0]  w_last_nxt;
    logic [BC_W-1:0]   w_burst_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_req_nxt;
    logic [NREQ-1:0]   w_rvalid_nxt;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .i_req (req_i),
        .i_ptr (r_ptr),
        .o_gnt (w_rr_gnt),
        .o_idx (w_rr_idx)
    );

    always_comb begin
        // The last winner keeps the port while it holds lock and has burst
        // budget left; once the budget is spent, round robin decides, which
        // still returns the same requester when nobody else is waiting.
        w_keep  = req_i[r_last] & lock_i[r_last] & (r_burst < c_max_burst);
        w_win   = w_keep ? r_last : w_rr_idx;
        // A falling gray_ready suppresses the grant in the same cycle.
        w_grant = !reset && (r_state == ARB_RUN) && gray_ready && (|req_i) &&
                  (w_keep || (|w_rr_gnt));

        gnt_o   = w_grant ? (NREQ'(1) << w_win) : '0;

        w_state_nxt  = gray_ready ? ARB_RUN : ARB_WAIT_RDY;
        w_ptr_nxt    = r_ptr;
        w_last_nxt   = r_last;
        w_burst_nxt  = r_burst;
        w_addr_nxt   = r_addr;
        w_req_nxt    = 1'b0;
        w_rvalid_nxt = '0;

        if (w_grant) begin
            w_addr_nxt   = addr_i[int'(w_win)*ADDR_W +: ADDR_W];
            w_req_nxt    = 1'b1;
            w_rvalid_nxt = NREQ'(1) << w_win;
            w_last_nxt   = w_win;
            if (!w_keep) begin
                w_ptr_nxt = (w_win == c_last_idx) ? '0 : w_win + IDX_W'(1);
            end
            if (w_win == r_last) begin
                if (r_burst < c_max_burst) begin
                    w_burst_nxt = r_burst + BC_W'(1);
                end
            end else begin
                w_burst_nxt = BC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ARB_WAIT_RDY;
            r_ptr    <= '0;
            r_last   <= '0;
            r_burst  <= '0;
            r_addr   <= '0;
            r_req    <= 1'b0;
            r_rvalid <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_last   <= w_last_nxt;
            r_burst  <= w_burst_nxt;
            r_addr   <= w_addr_nxt;
            r_req    <= w_req_nxt;
            r_rvalid <= w_rvalid_nxt;
        end
    end

    assign gray_addr = r_addr;
    assign gray_req  = r_req;
    assign rvalid_o  = r_rvalid;
    assign rdata_o   = gray_data;

endmodule : gray_rd_arb
`default_nettype wire

// File: tb/tb_gray_rd_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_rd_arb
//  Description : Self-checking bench for gray_rd_arb: directed vector table
//                for the documented sequences, then randomized traffic, all
//                compared against a behavioural arbitration model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_rd_arb;

    localparam int NREQ      = 2;
    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   gray_ready;
    logic [DATA_W-1:0]      gray_data;
    logic [ADDR_W-1:0]      gray_addr;
    logic                   gray_req;
    logic [NREQ-1:0]        req_i;
    logic [NREQ-1:0]        lock_i;
    logic [NREQ*ADDR_W-1:0] addr_i;
    logic [NREQ-1:0]        gnt_o;
    logic [NREQ-1:0]        rvalid_o;
    logic [DATA_W-1:0]      rdata_o;

    always #5 clk = ~clk;

    gray_rd_arb #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_data(gray_data),
        .gray_addr(gray_addr), .gray_req(gray_req), .req_i(req_i), .lock_i(lock_i),
        .addr_i(addr_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o)
    );

    // Memory contents are a fixed scramble of the address.
    function automatic logic [DATA_W-1:0] mem_of(input logic [ADDR_W-1:0] a);
        return DATA_W'(a * 7 + 3) ^ DATA_W'(a >> 6);
    endfunction
    assign gray_data = mem_of(gray_addr);

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int m_run, m_ptr, m_last, m_burst, m_req, m_rvalid, m_addr;

    typedef struct {
        logic       rst;
        logic       rdy;
        logic [1:0] rq;
        logic [1:0] lk;
        int         a0;
        int         a1;
        int         gnt;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_ptr = 0; m_last = 0; m_burst = 0;
        m_req = 0; m_rvalid = 0; m_addr = 0;
    endtask

    // One clock cycle: apply inputs, check against the model, advance model.
    task automatic cycle(input logic rst, input logic rdy, input logic [1:0] rq,
                         input logic [1:0] lk, input int a0, input int a1,
                         input int tbl_gnt);
        int w;
        bit kept, grant;
        reset      = rst;
        gray_ready = rdy;
        req_i      = rq;
        lock_i     = lk;
        addr_i     = {ADDR_W'(a1), ADDR_W'(a0)};

        // Winner selection from the arbitration rules
        grant = !rst && (m_run != 0) && rdy && (rq != 0);
        kept  = 0;
        w     = 0;
        if (grant) begin
            if (rq[m_last] && lk[m_last] && m_burst < MAX_BURST) begin
                w = m_last; kept = 1;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    int j;
                    j = (m_ptr + k) % NREQ;
                    if (rq[j]) begin w = j; break; end
                end
            end
        end

        @(negedge clk);
        chk("gnt_o",    int'(gnt_o),    grant ? (1 << w) : 0);
        chk("gray_req", int'(gray_req), m_req);
        chk("rvalid_o", int'(rvalid_o), m_rvalid);
        chk("gray_addr", int'(gray_addr), m_addr);
        if (m_rvalid != 0) chk("rdata_o", int'(rdata_o), int'(mem_of(ADDR_W'(m_addr))));
        if (tbl_gnt >= 0) chk("table_gnt", int'(gnt_o), tbl_gnt);

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_run = rdy ? 1 : 0;
            if (grant) begin
                m_addr   = (w == 0) ? (a0 & 16'h3fff) : (a1 & 16'h3fff);
                m_req    = 1;
                m_rvalid = 1 << w;
                if (!kept) m_ptr = (w + 1) % NREQ;
                m_burst  = (w == m_last) ? ((m_burst < MAX_BURST) ? m_burst + 1 : m_burst) : 1;
                m_last   = w;
            end else begin
                m_req    = 0;
                m_rvalid = 0;
            end
        end
        #1;
    endtask

    vec_t vt[$];

    initial begin
        // rst rdy rq lk a0 a1 gnt
        vt.push_back('{1, 0, 2'b11, 2'b00, 0, 0, 0});
        vt.push_back('{1, 0, 2'b11, 2'b00, 0, 0, 0});
        vt.push_back('{1, 0, 2'b11, 2'b00, 0, 0, 0});
        vt.push_back('{0, 0, 2'b00, 2'b00, 5, 0, 0});
        vt.push_back('{0, 1, 2'b01, 2'b00, 5, 0, 0});      // leaving WAIT_RDY
        vt.push_back('{0, 1, 2'b01, 2'b00, 5, 0, 1});
        vt.push_back('{0, 1, 2'b01, 2'b00, 6, 0, 1});
        vt.push_back('{0, 1, 2'b00, 2'b00, 7, 0, 0});
        vt.push_back('{0, 1, 2'b10, 2'b00, 7, 32, 2});
        vt.push_back('{0, 1, 2'b11, 2'b00, 16, 33, 1});    // alternation
        vt.push_back('{0, 1, 2'b11, 2'b00, 17, 33, 2});
        vt.push_back('{0, 1, 2'b11, 2'b00, 17, 34, 1});
        vt.push_back('{0, 1, 2'b11, 2'b00, 18, 34, 2});
        for (int i = 0; i < 10; i++)                         // lock: 0,0,0,0,1 x2
            vt.push_back('{0, 1, 2'b11, 2'b01, 100 + i, 200 + i, (i % 5 == 4) ? 2 : 1});
        for (int i = 0; i < 6; i++)                          // lone locked requester
            vt.push_back('{0, 1, 2'b01, 2'b01, 300 + i, 0, 1});
        vt.push_back('{0, 0, 2'b11, 2'b00, 400, 500, 0});   // ready dropped
        vt.push_back('{0, 0, 2'b11, 2'b00, 400, 500, 0});
        vt.push_back('{0, 1, 2'b11, 2'b00, 400, 500, 0});
        vt.push_back('{0, 1, 2'b11, 2'b00, 400, 500, 2});   // pointer unchanged
        vt.push_back('{0, 1, 2'b11, 2'b00, 400, 501, 1});
        vt.push_back('{0, 1, 2'b11, 2'b00, 401, 501, 2});
        vt.push_back('{1, 1, 2'b11, 2'b00, 401, 502, 0});   // reset after grant to 1
        vt.push_back('{0, 1, 2'b11, 2'b00, 401, 502, 0});
        vt.push_back('{0, 1, 2'b11, 2'b00, 401, 502, 1});

        reset = 1'b1; gray_ready = 1'b0; req_i = '0; lock_i = '0; addr_i = '0;
        @(posedge clk);
        #1;
        model_reset();

        foreach (vt[i])
            cycle(vt[i].rst, vt[i].rdy, vt[i].rq, vt[i].lk, vt[i].a0, vt[i].a1, vt[i].gnt);

        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) != 0),
                  2'($urandom), 2'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                  int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_gray_rd_arb
`default_nettype wire

// File: doc/gray_rd_arb.md
Name: gray_rd_arb

Overview:
- Round-robin arbiter that shares the single gray-image read port among NREQ requesters, for example the LBP engine and a histogram/preview engine.
- The memory side is the standard gray port (gray_addr/gray_req/gray_ready/gray_data). The arbiter registers the address; gray_data is sampled by the winner at the end of the cycle that address is presented.
- Provides per-requester grant/valid handshakes, optional burst locking, and stalls while memory is not ready.

Parameters:
- NREQ, 2, number of requesters (2..4)
- ADDR_W, 14, gray address width (128x128 image)
- DATA_W, 8, gray pixel width
- MAX_BURST, 4, max consecutive locked grants to one requester while another is waiting

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- gray_ready  in  1  memory ready; no reads are issued while low
- gray_data  in  DATA_W  memory read data, valid in the cycle gray_addr is presented
- gray_addr  out  ADDR_W  registered read address
- gray_req  out  1  registered read strobe
- req_i  in  NREQ  per-requester read request
- lock_i  in  NREQ  per-requester burst lock (hold grant while asserted)
- addr_i  in  NREQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W]
- gnt_o  out  NREQ  combinational one-hot grant; the request is consumed at this edge
- rvalid_o  out  NREQ  registered one-hot; rdata_o is valid for that requester this cycle
- rdata_o  out  DATA_W  pass-through of gray_data

Behaviour:
- Reset (synchronous):
  - gray_req=0, gray_addr=0, rvalid_o=0.
  - Round-robin pointer set so requester 0 has top priority; burst counter 0; state WAIT_RDY.
- States:
  - WAIT_RDY: gnt_o=0. Go to RUN when gray_ready=1.
  - RUN: arbitrate every cycle. Go to WAIT_RDY when gray_ready=0.
  - The gray_ready=0 check takes effect in the same cycle: when gray_ready=0, gnt_o=0 regardless of state.
- Arbitration (RUN, gray_ready=1, req_i≠0):
  - Winner = first requesting index at or after ptr, wrapping modulo NREQ.
  - Exception: if the last winner L still has req_i[L]&lock_i[L] and burst_cnt<MAX_BURST, L wins again.
  - A waiting requester only breaks the lock at MAX_BURST. With no other requester waiting, the lock holds indefinitely and burst_cnt saturates.
- Registration on a grant to winner w:
  - Next cycle: gray_addr=addr_i[w], gray_req=1, rvalid_o=onehot(w).
  - ptr=(w+1)%NREQ unless w was kept by the lock.
  - burst_cnt increments on a repeat grant to the same requester, else resets to 1.
- No grant: gray_req=0, rvalid_o=0, gray_addr holds its value.
- Latency: request at edge k → data captured by the requester at edge k+1. Throughput is one read per cycle.
- Requester contract: addr_i is stable while req_i is high. The requester advances its address on the edge where gnt_o[i]=1.
- rdata_o=gray_data always. It is only meaningful where rvalid_o≠0.
- Simultaneous events:
  - If gray_ready falls in the same cycle a grant would occur, the grant is suppressed.
  - The rvalid from the previous edge still completes.
- Reset mid-stream: a pending rvalid is dropped (rvalid_o=0 after the reset edge) and is not replayed.
- Invariants: gnt_o and rvalid_o are one-hot or zero. req_i bits outside NREQ are not present.

Decomposition:
- Shared package lbp_pkg holds:
  - ADDR_W=14, DATA_W=8, IMG_W=128
  - state encoding constants ARB_WAIT_RDY=1'b0, ARB_RUN=1'b1
- One sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, index.
  - Instantiated once.

Test Plan:
- reset high 3 cycles, gray_ready=0, req_i=2'b11 → gnt_o=0, gray_req=0, gray_addr=0, rvalid_o=0 throughout.
- gray_ready=1, only req0 with addr 0x0005 then 0x0006 → gnt_o[0] on consecutive cycles; gray_addr=0x0005 then 0x0006; rvalid_o=01 each following cycle; rdata_o=mem[0x0005], then mem[0x0006].
- Both requesting, no lock → grant order 0,1,0,1; rvalid_o lags gnt_o by one cycle; gray_addr alternates addr_i[0] and addr_i[1].
- lock_i[0]=1, req_i=11, MAX_BURST=4 → grants 0,0,0,0,1,0,0,0,0,1. With req1 low, requester 0 is granted every cycle indefinitely.
- gray_ready dropped for 2 cycles mid-stream → gnt_o=0 in those cycles; gray_req=0 from the next edge; service resumes at the unchanged pointer.
- reset pulsed one cycle after a grant to requester 1 → rvalid_o=0 after reset; the first post-reset grant with req_i=11 goes to requester 0.
